// File: rtl/opb_status_bank_simulink2ppc.sv
// OPB slave exposing a bank of status channels (transparent or sticky) to the PPC,
// plus a freeze control word and a read-only geometry word.
module opb_status_bank_simulink2ppc #(
  parameter logic [31:0]           C_BASEADDR    = 32'h01080C00,
  parameter logic [31:0]           C_HIGHADDR    = 32'h01080CFF,
  parameter int                    C_NUM_REGS    = 4,
  parameter int                    C_DATA_WIDTH  = 32,
  parameter logic [C_NUM_REGS-1:0] C_STICKY_MASK = '0
) (
  input  logic                               OPB_Clk,
  input  logic                               OPB_Rst,
  input  logic [0:31]                        OPB_ABus,
  input  logic [0:3]                         OPB_BE,
  input  logic [0:31]                        OPB_DBus,
  input  logic                               OPB_RNW,
  input  logic                               OPB_select,
  input  logic                               OPB_seqAddr,
  output logic [0:31]                        Sl_DBus,
  output logic                               Sl_errAck,
  output logic                               Sl_retry,
  output logic                               Sl_toutSup,
  output logic                               Sl_xferAck,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] user_data_in
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [29:0] CTRL_OFF  = 30'(C_NUM_REGS);
  localparam logic [29:0] INFO_OFF  = 30'(C_NUM_REGS + 1);
  localparam logic [31:0] INFO_WORD = {8'h0, 8'(C_DATA_WIDTH), 8'h0, 8'(C_NUM_REGS)};

  logic [1:0]  state_reg, state_next;
  logic        freeze_reg;
  logic [31:0] dbus_reg;
  logic [31:0] rdata;

  // Re-view the big-endian OPB buses as ordinary numeric vectors.
  logic [31:0] abus, wdata, addr_diff;
  logic [29:0] offset;
  logic        hit, start, wr_en;
  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] chan_flat;

  assign abus      = OPB_ABus;
  assign wdata     = OPB_DBus;
  assign addr_diff = abus - C_BASEADDR;
  assign offset    = addr_diff[31:2];
  assign hit       = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign start     = (state_reg == IDLE) && hit;
  assign wr_en     = start && !OPB_RNW;

  logic unused_ok;
  assign unused_ok = ^{OPB_BE, OPB_seqAddr, addr_diff[1:0], wdata};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hit) state_next = ACK;
      ACK:     state_next = WAIT;
      WAIT:    if (!OPB_select) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_reg  <= IDLE;
      freeze_reg <= 1'b0;
      dbus_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dbus_reg  <= start ? rdata : 32'h0;
      if (wr_en && offset == CTRL_OFF)
        freeze_reg <= wdata[0];
    end
  end

  generate
    for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_chan
      logic [C_DATA_WIDTH-1:0] chan_reg;
      logic [C_DATA_WIDTH-1:0] in_k;
      assign in_k = user_data_in[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
      assign chan_flat[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = chan_reg;

      if (C_STICKY_MASK[gi]) begin : g_sticky
        // Write-1-to-clear; a bit set by the input in the same cycle survives the clear.
        logic                    wr_k;
        logic [C_DATA_WIDTH-1:0] keep_k, set_k;
        assign wr_k   = wr_en && (offset == 30'(gi));
        assign keep_k = wr_k ? (chan_reg & ~wdata[C_DATA_WIDTH-1:0]) : chan_reg;
        assign set_k  = freeze_reg ? '0 : in_k;
        always_ff @(posedge OPB_Clk) begin
          if (OPB_Rst) chan_reg <= '0;
          else         chan_reg <= keep_k | set_k;
        end
      end else begin : g_transparent
        always_ff @(posedge OPB_Clk) begin
          if (OPB_Rst)          chan_reg <= '0;
          else if (!freeze_reg) chan_reg <= in_k;
        end
      end
    end
  endgenerate

  // Read data comes from the registered values, i.e. before this cycle's update.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < C_NUM_REGS; k++)
      if (offset == 30'(k)) rdata = 32'(chan_flat[k*C_DATA_WIDTH +: C_DATA_WIDTH]);
    if (offset == CTRL_OFF) rdata = {31'b0, freeze_reg};
    if (offset == INFO_OFF) rdata = INFO_WORD;
  end

  assign Sl_DBus    = dbus_reg;
  assign Sl_xferAck = (state_reg == ACK);
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_status_bank_simulink2ppc.sv
// Directed bench for the OPB status bank: 4 channels x 16 bits, channel 1 sticky.
module tb_opb_status_bank_simulink2ppc;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw, sel, seqaddr;
  logic [0:31] sl_dbus;
  logic        errack, retry, toutsup, xferack;
  logic [63:0] user_data_in;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  opb_status_bank_simulink2ppc #(
    .C_BASEADDR   (32'h01080C00),
    .C_HIGHADDR   (32'h01080CFF),
    .C_NUM_REGS   (4),
    .C_DATA_WIDTH (16),
    .C_STICKY_MASK(4'b0010)
  ) dut (
    .OPB_Clk     (clk),
    .OPB_Rst     (rst),
    .OPB_ABus    (abus),
    .OPB_BE      (be),
    .OPB_DBus    (dbus),
    .OPB_RNW     (rnw),
    .OPB_select  (sel),
    .OPB_seqAddr (seqaddr),
    .Sl_DBus     (sl_dbus),
    .Sl_errAck   (errack),
    .Sl_retry    (retry),
    .Sl_toutSup  (toutsup),
    .Sl_xferAck  (xferack),
    .user_data_in(user_data_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    user_data_in[k*16 +: 16] = v;
  endtask

  // One OPB transfer, select held for 'hold' cycles; called and returns on a negedge.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic rd,
                      input logic [31:0] wd, input logic exp_ack,
                      input logic [31:0] exp_data, input int hold);
    int   acks;
    exp_t e;
    abus = addr; rnw = rd; dbus = wd; sel = 1'b1;
    if (exp_ack) exp_q.push_back('{chk: rd, data: exp_data});
    acks = 0;
    for (int c = 0; c < hold + 3; c++) begin
      @(negedge clk);
      if (c == 0) check({tag, " latency"}, {31'b0, xferack}, {31'b0, exp_ack});
      if (xferack) begin
        acks++;
        check({tag, " ack_expected"}, {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.chk) check({tag, " data"}, sl_dbus, e.data);
        end
      end else begin
        check({tag, " idle_dbus"}, sl_dbus, 32'h0);
      end
      if (c == hold - 1) sel = 1'b0;
    end
    check({tag, " ack_count"}, 32'(acks), exp_ack ? 32'd1 : 32'd0);
    check({tag, " q_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; abus = '0; be = 4'hF; dbus = '0; rnw = 1'b1; sel = 1'b0; seqaddr = 1'b0;
    user_data_in = '0;
    idle(3);
    check("reset ack", {31'b0, xferack}, 32'd0);
    check("reset dbus", sl_dbus, 32'h0);
    check("reset consts", {29'b0, errack, retry, toutsup}, 32'd0);
    rst = 1'b0;
    idle(1);
    xfer("rst ctrl", 32'h01080C10, 1'b1, 32'h0, 1'b1, 32'h0, 1);
    xfer("rst ch1",  32'h01080C04, 1'b1, 32'h0, 1'b1, 32'h0, 1);

    // Transparent channel read
    set_ch(0, 16'hBEEF); idle(1);
    xfer("ch0 read", 32'h01080C00, 1'b1, 32'h0, 1'b1, 32'h0000BEEF, 1);

    // Sticky accumulate, W1C, set-wins-over-clear
    set_ch(1, 16'h0001); idle(1);
    set_ch(1, 16'h0100); idle(1);
    set_ch(1, 16'h0000); idle(1);
    xfer("ch1 accum", 32'h01080C04, 1'b1, 32'h0, 1'b1, 32'h00000101, 1);
    xfer("ch1 w1c",   32'h01080C04, 1'b0, 32'h00000001, 1'b1, 32'h0, 1);
    xfer("ch1 after", 32'h01080C04, 1'b1, 32'h0, 1'b1, 32'h00000100, 1);
    set_ch(1, 16'h0004); idle(1);
    xfer("ch1 setwin w", 32'h01080C04, 1'b0, 32'h00000104, 1'b1, 32'h0, 1);
    set_ch(1, 16'h0000); idle(1);
    xfer("ch1 setwin r", 32'h01080C04, 1'b1, 32'h0, 1'b1, 32'h00000004, 1);
    xfer("ch1 clr w",    32'h01080C04, 1'b0, 32'h00000004, 1'b1, 32'h0, 1);
    xfer("ch1 clr r",    32'h01080C04, 1'b1, 32'h0, 1'b1, 32'h00000000, 1);

    // Freeze
    set_ch(2, 16'h1234); idle(1);
    xfer("freeze w", 32'h01080C10, 1'b0, 32'h00000001, 1'b1, 32'h0, 1);
    set_ch(2, 16'h5678); set_ch(1, 16'h0008); idle(1);
    set_ch(1, 16'h0000); idle(1);
    xfer("frozen ch2", 32'h01080C08, 1'b1, 32'h0, 1'b1, 32'h00001234, 1);
    xfer("ctrl read",  32'h01080C10, 1'b1, 32'h0, 1'b1, 32'h00000001, 1);
    xfer("unfreeze w", 32'h01080C10, 1'b0, 32'h00000000, 1'b1, 32'h0, 1);
    idle(1);
    xfer("thawed ch2", 32'h01080C08, 1'b1, 32'h0, 1'b1, 32'h00005678, 1);
    xfer("lost stky",  32'h01080C04, 1'b1, 32'h0, 1'b1, 32'h00000000, 1);

    // Map boundaries and ignored writes
    xfer("info read",   32'h01080C14, 1'b1, 32'h0, 1'b1, 32'h00100004, 1);
    xfer("info write",  32'h01080C14, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
    xfer("info reread", 32'h01080C14, 1'b1, 32'h0, 1'b1, 32'h00100004, 1);
    xfer("off6 read",   32'h01080C18, 1'b1, 32'h0, 1'b1, 32'h00000000, 1);
    xfer("off32 read",  32'h01080C80, 1'b1, 32'h0, 1'b1, 32'h00000000, 1);
    xfer("above high",  32'h01080D00, 1'b1, 32'h0, 1'b0, 32'h0, 1);
    xfer("below base",  32'h01080BFC, 1'b1, 32'h0, 1'b0, 32'h0, 1);
    xfer("ch0 write",   32'h01080C00, 1'b0, 32'h00000000, 1'b1, 32'h0, 1);
    xfer("ch0 kept",    32'h01080C00, 1'b1, 32'h0, 1'b1, 32'h0000BEEF, 1);
    set_ch(0, 16'hCAFE);
    xfer("pre-update",  32'h01080C00, 1'b1, 32'h0, 1'b1, 32'h0000BEEF, 1);

    // Long select: single ack
    xfer("long sel", 32'h01080C00, 1'b1, 32'h0, 1'b1, 32'h0000CAFE, 5);

    // Reset during a pending transfer
    set_ch(1, 16'h0003); idle(2);
    xfer("pre-rst frz", 32'h01080C10, 1'b0, 32'h00000001, 1'b1, 32'h0, 1);
    abus = 32'h01080C04; rnw = 1'b1; sel = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst cycle ack", {31'b0, xferack}, 32'd0);
    check("rst cycle dbus", sl_dbus, 32'h0);
    rst = 1'b0; sel = 1'b0; set_ch(1, 16'h0010);
    @(negedge clk);
    check("post rst ack", {31'b0, xferack}, 32'd0);
    idle(1);
    xfer("rst ctrl clr", 32'h01080C10, 1'b1, 32'h0, 1'b1, 32'h00000000, 1);
    xfer("rst ch1 or",   32'h01080C04, 1'b1, 32'h0, 1'b1, 32'h00000010, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
